// File: rtl/output_write_ctrl.sv
// output_write_ctrl
// Sequences result words from the multiplier datapath into the output memory.
// Results arrive over a valid/ready handshake, are buffered in a small FIFO
// and are written to consecutive memory addresses. When a frame of NUM_WORDS
// words has been written the controller parks in DONE until the next start.
//
// Optional build macro: OUTCTRL_WRAP_EN
//   When defined, the controller streams continuously. After the last word of
//   a frame the address and wr_count wrap to 0, done pulses for one cycle and
//   the state stays RUN.
//
// Ports:
//   clk       in   clock, all state on posedge
//   rst       in   synchronous active-high reset
//   start     in   one-cycle pulse, begins a frame from IDLE or DONE
//   in_valid  in   result word available
//   in_word   in   result word
//   in_ready  out  controller accepts in_word this cycle
//   mem_hold  in   host owns the memory, writes are suppressed
//   mem_we    out  memory write enable
//   mem_addr  out  memory address
//   mem_word  out  memory write data
//   busy      out  state is RUN
//   done      out  frame complete
//   wr_count  out  words written in the current frame
module output_write_ctrl #(
    parameter int NUM_WORDS  = 8,
    parameter int WORD_BITS  = 32,
    parameter int ADDR_BITS  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [WORD_BITS-1:0] in_word,
    output logic                 in_ready,
    input  logic                 mem_hold,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_word,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS:0]   wr_count
);

    localparam int PTR_BITS = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [PTR_BITS:0]    OCC_ZERO   = {(PTR_BITS+1){1'b0}};
    localparam logic [PTR_BITS:0]    OCC_ONE    = (PTR_BITS+1)'(1);
    localparam logic [PTR_BITS:0]    OCC_FULL   = (PTR_BITS+1)'(FIFO_DEPTH);
    localparam logic [PTR_BITS-1:0]  PTR_ZERO   = {PTR_BITS{1'b0}};
    localparam logic [PTR_BITS-1:0]  PTR_ONE    = PTR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_ZERO  = {ADDR_BITS{1'b0}};
    localparam logic [ADDR_BITS-1:0] ADDR_ONE   = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]   CNT_ZERO   = {(ADDR_BITS+1){1'b0}};
    localparam logic [ADDR_BITS:0]   CNT_ONE    = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS:0]   LAST_CNT   = (ADDR_BITS+1)'(NUM_WORDS - 1);

    logic [1:0]           state_r;
    logic [WORD_BITS-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr_r;
    logic [PTR_BITS-1:0]  rd_ptr_r;
    logic [PTR_BITS:0]    occ_r;
    logic [ADDR_BITS-1:0] addr_r;
    logic [ADDR_BITS:0]   wr_count_r;

    logic run_s;
    logic fifo_full_s;
    logic fifo_empty_s;
    logic cap_reached_s;
    logic in_ready_s;
    logic push_s;
    logic pop_s;
    logic last_write_s;
    logic fifo_clear_s;

`ifdef OUTCTRL_WRAP_EN
    logic done_pulse_r;
`else
    localparam logic [ADDR_BITS:0] FRAME_CNT = (ADDR_BITS+1)'(NUM_WORDS);
    logic [ADDR_BITS:0] pushed_r;
`endif

    // Handshake, write-enable and frame-boundary decode from registered state
    always_comb begin
        run_s        = (state_r == ST_RUN);
        fifo_full_s  = (occ_r == OCC_FULL);
        fifo_empty_s = (occ_r == OCC_ZERO);
`ifdef OUTCTRL_WRAP_EN
        cap_reached_s = 1'b0;
`else
        // Never accept more words than one frame holds, so nothing is left
        // stranded in the FIFO when the frame ends.
        cap_reached_s = (pushed_r == FRAME_CNT);
`endif
        in_ready_s   = run_s && !fifo_full_s && !cap_reached_s;
        push_s       = in_valid && in_ready_s;
        pop_s        = run_s && !fifo_empty_s && !mem_hold;
        last_write_s = pop_s && (wr_count_r == LAST_CNT);
        // Starting a frame from IDLE/DONE flushes any buffered state.
        fifo_clear_s = start && !run_s;
    end

    assign in_ready = in_ready_s;
    assign mem_we   = pop_s;
    assign mem_addr = addr_r;
    assign mem_word = fifo_mem_r[rd_ptr_r];
    assign busy     = run_s;
    assign wr_count = wr_count_r;
`ifdef OUTCTRL_WRAP_EN
    assign done = done_pulse_r;
`else
    assign done = (state_r == ST_DONE);
`endif

    // FIFO storage write on accepted handshake
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= in_word;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || fifo_clear_s) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            occ_r    <= OCC_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_ONE;
                2'b01:   occ_r <= occ_r - OCC_ONE;
                default: occ_r <= occ_r;
            endcase
        end
    end

`ifndef OUTCTRL_WRAP_EN
    // Count of words accepted in the current frame (push cap)
    always_ff @(posedge clk) begin
        if (rst || fifo_clear_s) begin
            pushed_r <= CNT_ZERO;
        end else if (push_s) begin
            pushed_r <= pushed_r + CNT_ONE;
        end
    end
`endif

    // Frame state machine with address and written-word counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            addr_r     <= ADDR_ZERO;
            wr_count_r <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r    <= ST_RUN;
                        addr_r     <= ADDR_ZERO;
                        wr_count_r <= CNT_ZERO;
                    end
                end
                ST_RUN: begin
                    if (pop_s) begin
`ifdef OUTCTRL_WRAP_EN
                        if (last_write_s) begin
                            addr_r     <= ADDR_ZERO;
                            wr_count_r <= CNT_ZERO;
                        end else begin
                            addr_r     <= addr_r + ADDR_ONE;
                            wr_count_r <= wr_count_r + CNT_ONE;
                        end
`else
                        addr_r     <= addr_r + ADDR_ONE;
                        wr_count_r <= wr_count_r + CNT_ONE;
                        if (last_write_s) begin
                            state_r <= ST_DONE;
                        end
`endif
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef OUTCTRL_WRAP_EN
    // One-cycle done pulse following each final-word write
    always_ff @(posedge clk) begin
        if (rst) begin
            done_pulse_r <= 1'b0;
        end else begin
            done_pulse_r <= last_write_s;
        end
    end
`endif

endmodule

// File: tb/tb_output_write_ctrl.sv
// Directed self-checking bench for output_write_ctrl.
// Inputs change 1 time unit after a posedge; outputs are sampled on negedge.
module tb_output_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [31:0] in_word;
    logic        in_ready;
    logic        mem_hold;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [31:0] mem_word;
    logic        busy;
    logic        done;
    logic [3:0]  wr_count;

    int errors = 0;
    int checks = 0;

    output_write_ctrl #(
        .NUM_WORDS (8),
        .WORD_BITS (32),
        .ADDR_BITS (3),
        .FIFO_DEPTH(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_valid(in_valid),
        .in_word (in_word),
        .in_ready(in_ready),
        .mem_hold(mem_hold),
        .mem_we  (mem_we),
        .mem_addr(mem_addr),
        .mem_word(mem_word),
        .busy    (busy),
        .done    (done),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_word = 32'hDEAD_BEEF; mem_hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL reset_wr_count got %0d want 0", wr_count); end
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got %b want 0", in_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL idle_mem_we got %b want 0", mem_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
        tick();
        in_valid = 1'b0;
    endtask

    // Called one cycle after the start edge. Pushes 8 words base*1..base*8 on
    // consecutive cycles and checks every cycle through the DONE cycle.
    task automatic do_stream(input logic [31:0] base, input int glitch, input string tag);
        logic        exp_we;
        logic        exp_ready;
        logic [2:0]  exp_addr;
        logic [31:0] exp_word;
        logic [3:0]  exp_cnt;
        for (int c = 0; c < 10; c++) begin
            in_valid  = (c < 8);
            in_word   = base * 32'(c + 1);
            start     = (c == glitch);
            exp_we    = (c >= 1 && c <= 8);
            exp_ready = (c < 8);
            exp_addr  = (c == 0) ? 3'd0 : 3'(c - 1);
            exp_word  = base * 32'(c);
            exp_cnt   = (c == 0) ? 4'd0 : 4'(c - 1);
            @(negedge clk);
            checks++; if (mem_we !== exp_we) begin errors++; $display("FAIL %s_we c=%0d got %b want %b", tag, c, mem_we, exp_we); end
            checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL %s_ready c=%0d got %b want %b", tag, c, in_ready, exp_ready); end
            checks++; if (wr_count !== exp_cnt) begin errors++; $display("FAIL %s_wr_count c=%0d got %0d want %0d", tag, c, wr_count, exp_cnt); end
            checks++; if (busy !== (c <= 8)) begin errors++; $display("FAIL %s_busy c=%0d got %b", tag, c, busy); end
            checks++; if (done !== (c == 9)) begin errors++; $display("FAIL %s_done c=%0d got %b", tag, c, done); end
            if (exp_we || c == 0) begin
                checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL %s_addr c=%0d got %0d want %0d", tag, c, mem_addr, exp_addr); end
            end
            if (exp_we) begin
                checks++; if (mem_word !== exp_word) begin errors++; $display("FAIL %s_word c=%0d got %h want %h", tag, c, mem_word, exp_word); end
            end
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_stream();
        start = 1'b1;
        tick();
        start = 1'b0;
        do_stream(32'h0000_0011, -1, "stream");
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stream_after_ready got %b want 0", in_ready); end
        checks++; if (wr_count !== 4'd8) begin errors++; $display("FAIL stream_after_cnt got %0d want 8", wr_count); end
        tick();
    endtask

    task automatic test_restart();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL restart_done got %b want 0", done); end
        checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL restart_wr_count got %0d want 0", wr_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL restart_ready got %b want 1", in_ready); end
        tick();
        // start pulse at cycle 3 lands while RUN and must be ignored
        do_stream(32'h0101_0101, 3, "restart");
    endtask

    task automatic test_hold();
        int          idx;
        logic        exp_ready;
        logic        exp_we;
        logic [2:0]  exp_addr;
        logic [31:0] exp_word;
        logic [3:0]  exp_cnt;
        idx      = 0;
        mem_hold = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 15; c++) begin
            mem_hold  = (c < 6);
            in_valid  = (idx < 8);
            in_word   = 32'hC0DE_0000 + 32'(idx);
            exp_ready = (c < 4) || (c >= 7 && c <= 10);
            exp_we    = (c >= 6 && c <= 13);
            exp_addr  = 3'(c - 6);
            exp_word  = 32'hC0DE_0000 + 32'(c - 6);
            exp_cnt   = (c <= 6) ? 4'd0 : 4'(c - 6);
            @(negedge clk);
            checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL hold_ready c=%0d got %b want %b", c, in_ready, exp_ready); end
            checks++; if (mem_we !== exp_we) begin errors++; $display("FAIL hold_we c=%0d got %b want %b", c, mem_we, exp_we); end
            checks++; if (wr_count !== exp_cnt) begin errors++; $display("FAIL hold_wr_count c=%0d got %0d want %0d", c, wr_count, exp_cnt); end
            checks++; if (done !== (c == 14)) begin errors++; $display("FAIL hold_done c=%0d got %b", c, done); end
            if (exp_we) begin
                checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL hold_addr c=%0d got %0d want %0d", c, mem_addr, exp_addr); end
                checks++; if (mem_word !== exp_word) begin errors++; $display("FAIL hold_word c=%0d got %h want %h", c, mem_word, exp_word); end
            end
            if (exp_ready && in_valid) begin
                idx++;
            end
            tick();
        end
        mem_hold = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_word  = 32'h0000_0031 * 32'(c + 1);
            @(negedge clk);
            checks++; if (mem_we !== (c >= 1)) begin errors++; $display("FAIL midrst_we c=%0d got %b", c, mem_we); end
            if (c >= 1) begin
                checks++; if (mem_addr !== 3'(c - 1)) begin errors++; $display("FAIL midrst_addr c=%0d got %0d want %0d", c, mem_addr, c - 1); end
            end
            tick();
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL midrst_wr_count got %0d want 0", wr_count); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_mem_we got %b want 0", mem_we); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        do_stream(32'h0505_0505, -1, "post_rst");
    endtask

    task automatic test_wrap();
        logic        exp_we;
        logic [2:0]  exp_addr;
        logic [31:0] exp_word;
        logic [3:0]  exp_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 10);
            in_word  = 32'h5A00_0000 + 32'(c);
            exp_we   = (c >= 1 && c <= 10);
            exp_addr = 3'(c - 1);
            exp_word = 32'h5A00_0000 + 32'(c - 1);
            exp_cnt  = (c == 0) ? 4'd0 : 4'((c - 1) % 8);
            @(negedge clk);
            checks++; if (mem_we !== exp_we) begin errors++; $display("FAIL wrap_we c=%0d got %b want %b", c, mem_we, exp_we); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrap_busy c=%0d got %b want 1", c, busy); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready c=%0d got %b want 1", c, in_ready); end
            checks++; if (done !== (c == 9)) begin errors++; $display("FAIL wrap_done c=%0d got %b", c, done); end
            checks++; if (wr_count !== exp_cnt) begin errors++; $display("FAIL wrap_wr_count c=%0d got %0d want %0d", c, wr_count, exp_cnt); end
            if (exp_we) begin
                checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL wrap_addr c=%0d got %0d want %0d", c, mem_addr, exp_addr); end
                checks++; if (mem_word !== exp_word) begin errors++; $display("FAIL wrap_word c=%0d got %h want %h", c, mem_word, exp_word); end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef OUTCTRL_WRAP_EN
        test_wrap();
`else
        test_stream();
        test_restart();
        test_hold();
        test_mid_reset();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
